// File: rtl/evp_dispatch_if.sv
// evp_dispatch_if: instruction FIFO, evaluator and result FIFO signals of the EVP dispatcher.
interface evp_dispatch_if #(
    parameter int unsigned buffer_size = 1024
);
    localparam int unsigned AW = (buffer_size > 1) ? $clog2(buffer_size) : 1;

    // Instruction FIFO side
    logic          instr_empty;
    logic [31:0]   instr_data;
    logic          instr_rd_en;
    // Evaluator side
    logic          start_evp;
    logic          rst_instr;
    logic [2:0]    A;
    logic [15:0]   x;
    logic [AW-1:0] rd_addr_data;
    logic          done_evp;
    logic [31:0]   evp_result;
    logic [31:0]   evp_status;
    logic [AW-1:0] rd_addr_data_updated;
    // Result FIFO side
    logic          out_full;
    logic [31:0]   out_data;
    logic          out_wr_en;
    // Status
    logic          busy;

    modport master (
        input  instr_empty, instr_data, done_evp, evp_result, evp_status,
               rd_addr_data_updated, out_full,
        output instr_rd_en, start_evp, rst_instr, A, x, rd_addr_data,
               out_data, out_wr_en, busy
    );

    modport slave (
        output instr_empty, instr_data, done_evp, evp_result, evp_status,
               rd_addr_data_updated, out_full,
        input  instr_rd_en, start_evp, rst_instr, A, x, rd_addr_data,
               out_data, out_wr_en, busy
    );
endinterface

// File: rtl/evp_dispatch.sv
// evp_dispatch: pops instructions, drives the polynomial evaluator for EVP requests and
// pushes result/status word pairs to the result FIFO. Owns the persistent read pointer.
module evp_dispatch #(
    parameter int unsigned buffer_size = 1024
) (
    input logic           clk,
    input logic           rst,
    evp_dispatch_if.master bus
);
    localparam int unsigned AW = (buffer_size > 1) ? $clog2(buffer_size) : 1;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StClear  = 3'd3;
    localparam logic [2:0] StStart  = 3'd4;
    localparam logic [2:0] StWait   = 3'd5;
    localparam logic [2:0] StWrRes  = 3'd6;
    localparam logic [2:0] StWrStat = 3'd7;

    localparam logic [3:0]  OpEvp       = 4'h3;
    localparam logic [31:0] StatIllegal = 32'h0000_0003;

    logic [2:0]    state_q, state_d;
    logic [22:0]   instr_q, instr_d;    // {opcode, A, x}; reserved bits are never stored
    logic [2:0]    a_q, a_d;
    logic [15:0]   x_q, x_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   res_q, res_d;
    logic [31:0]   stat_q, stat_d;
    logic          rd_en_q, rd_en_d;
    logic          start_q, start_d;
    logic          rst_instr_q, rst_instr_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          wr_en_q, wr_en_d;
    logic          busy_q, busy_d;

    // Next-state and next-output decode; every output is a register, so each transition
    // also loads the output values for the state being entered. out_full is therefore
    // sampled the cycle before the corresponding push strobe.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        a_d         = a_q;
        x_d         = x_q;
        rd_ptr_d    = rd_ptr_q;
        res_d       = res_q;
        stat_d      = stat_q;
        out_data_d  = out_data_q;
        rd_en_d     = 1'b0;
        start_d     = 1'b0;
        rst_instr_d = 1'b1;
        wr_en_d     = 1'b0;

        case (state_q)
            StIdle: begin
                // A pop strobe raised last cycle moves us on; never pop twice.
                if (rd_en_q) begin
                    state_d = StFetch;
                end else if (!bus.instr_empty) begin
                    rd_en_d = 1'b1;
                end
            end
            StFetch: begin
                instr_d = {bus.instr_data[31:25], bus.instr_data[15:0]};
                state_d = StDecode;
            end
            StDecode: begin
                if (instr_q[22:19] == OpEvp) begin
                    a_d         = instr_q[18:16];
                    x_d         = instr_q[15:0];
                    rst_instr_d = 1'b0;
                    state_d     = StClear;
                end else begin
                    res_d      = 32'd0;
                    stat_d     = StatIllegal;
                    out_data_d = 32'd0;
                    wr_en_d    = !bus.out_full;
                    state_d    = StWrRes;
                end
            end
            StClear: begin
                start_d = 1'b1;
                state_d = StStart;
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (bus.done_evp) begin
                    res_d      = bus.evp_result;
                    stat_d     = bus.evp_status;
                    rd_ptr_d   = bus.rd_addr_data_updated;
                    out_data_d = bus.evp_result;
                    wr_en_d    = !bus.out_full;
                    state_d    = StWrRes;
                end
            end
            StWrRes: begin
                // wr_en_q set means the result word is being pushed this cycle.
                if (wr_en_q) begin
                    out_data_d = stat_q;
                    wr_en_d    = !bus.out_full;
                    state_d    = StWrStat;
                end else begin
                    out_data_d = res_q;
                    wr_en_d    = !bus.out_full;
                end
            end
            StWrStat: begin
                if (wr_en_q) begin
                    rd_en_d = !bus.instr_empty;
                    state_d = StIdle;
                end else begin
                    out_data_d = stat_q;
                    wr_en_d    = !bus.out_full;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            instr_q     <= '0;
            a_q         <= '0;
            x_q         <= '0;
            rd_ptr_q    <= '0;
            res_q       <= '0;
            stat_q      <= 32'hFFFF_FFFF;
            rd_en_q     <= 1'b0;
            start_q     <= 1'b0;
            rst_instr_q <= 1'b1;
            out_data_q  <= '0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            a_q         <= a_d;
            x_q         <= x_d;
            rd_ptr_q    <= rd_ptr_d;
            res_q       <= res_d;
            stat_q      <= stat_d;
            rd_en_q     <= rd_en_d;
            start_q     <= start_d;
            rst_instr_q <= rst_instr_d;
            out_data_q  <= out_data_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.instr_rd_en  = rd_en_q;
    assign bus.start_evp    = start_q;
    assign bus.rst_instr    = rst_instr_q;
    assign bus.A            = a_q;
    assign bus.x            = x_q;
    assign bus.rd_addr_data = rd_ptr_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_wr_en    = wr_en_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_evp_dispatch.sv
// tb_evp_dispatch: instruction FIFO, evaluator and result FIFO models around evp_dispatch,
// with a scoreboard of expected result-FIFO words.
module tb_evp_dispatch;
    typedef struct {
        int          lat;
        logic [31:0] res;
        logic [31:0] stat;
        logic [9:0]  ptr;
    } cfg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spur_req = 1'b0;
    logic full_smp = 1'b0;
    logic prev_rst_low = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int ev_cnt = 0;
    int clr_cnt = 0;
    int push_cnt = 0;

    logic [31:0] ififo[$];
    logic [31:0] expq[$];
    cfg_t        cfgq[$];
    cfg_t        cur;
    int          pop_cycles[$];
    int          start_cycles[$];
    int          done_cycles[$];
    int          push_cycles[$];
    logic [31:0] start_ptr[$];
    logic [31:0] start_ax[$];

    always #5 clk = ~clk;

    evp_dispatch_if #(.buffer_size(1024)) bus ();

    evp_dispatch #(.buffer_size(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic add_cfg(input int lat, input logic [31:0] res, input logic [31:0] stat,
                           input logic [9:0] ptr);
        cfg_t c;
        c.lat  = lat;
        c.res  = res;
        c.stat = stat;
        c.ptr  = ptr;
        cfgq.push_back(c);
    endtask

    task automatic wait_pushes(input int target, input int budget);
        int n = 0;
        while (push_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check_eq("push_wait", 32'(push_cnt >= target), 32'd1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cycles.size() < target && n < budget) begin
            tick();
            n++;
        end
        check_eq("done_wait", 32'(done_cycles.size() >= target), 32'd1);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n = 0;
        while (start_cycles.size() < target && n < budget) begin
            tick();
            n++;
        end
        check_eq("start_wait", 32'(start_cycles.size() >= target), 32'd1);
    endtask

    task automatic check_reset(input string pre);
        check_eq({pre, "_rd_en"},     32'(bus.instr_rd_en),  32'd0);
        check_eq({pre, "_start"},     32'(bus.start_evp),    32'd0);
        check_eq({pre, "_rst_instr"}, 32'(bus.rst_instr),    32'd1);
        check_eq({pre, "_A"},         32'(bus.A),            32'd0);
        check_eq({pre, "_x"},         32'(bus.x),            32'd0);
        check_eq({pre, "_rd_addr"},   32'(bus.rd_addr_data), 32'd0);
        check_eq({pre, "_wr_en"},     32'(bus.out_wr_en),    32'd0);
        check_eq({pre, "_out_data"},  bus.out_data,          32'd0);
        check_eq({pre, "_busy"},      32'(bus.busy),         32'd0);
    endtask

    // Instruction FIFO head: valid only in the cycle after the pop strobe.
    always @(posedge clk) begin
        full_smp <= bus.out_full;
        if (bus.instr_rd_en && ififo.size() != 0) begin
            bus.instr_data <= ififo.pop_front();
        end else begin
            bus.instr_data <= 32'hFFFF_FFFF;
        end
    end

    // Evaluator model plus output monitor and scoreboard, all mid-cycle.
    always @(negedge clk) begin : negedge_model
        logic hit;
        cyc++;
        bus.instr_empty = (ififo.size() == 0);
        hit = 1'b0;
        if (rst) begin
            ev_cnt = 0;
        end else if (bus.start_evp) begin
            if (cfgq.size() != 0) cur = cfgq.pop_front();
            ev_cnt = cur.lat;
        end else if (ev_cnt > 0) begin
            ev_cnt--;
            hit = (ev_cnt == 0);
        end
        bus.done_evp = hit | spur_req;
        if (hit) begin
            bus.evp_result           = cur.res;
            bus.evp_status           = cur.stat;
            bus.rd_addr_data_updated = cur.ptr;
            done_cycles.push_back(cyc);
        end else begin
            bus.evp_result           = 32'hBADB_AD00;
            bus.evp_status           = 32'h0000_0BAD;
            bus.rd_addr_data_updated = 10'h155;
        end

        if (!rst && bus.rst_instr === 1'b0) clr_cnt++;
        if (!rst && bus.start_evp === 1'b1) begin
            check_eq("clear_before_start", 32'(prev_rst_low), 32'd1);
            start_cycles.push_back(cyc);
            start_ptr.push_back(32'(bus.rd_addr_data));
            start_ax.push_back({13'd0, bus.A, bus.x});
        end
        prev_rst_low = (bus.rst_instr === 1'b0);
        if (!rst && bus.instr_rd_en === 1'b1) begin
            check_eq("pop_nonempty", 32'(ififo.size() != 0), 32'd1);
            pop_cycles.push_back(cyc);
        end
        if (!rst && bus.out_wr_en === 1'b1) begin
            push_cnt++;
            push_cycles.push_back(cyc);
            check_eq("push_not_full", 32'(full_smp), 32'd0);
            check_eq("push_expected", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) check_eq("push_data", bus.out_data, expq.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, pc0, dc0, pp0, k0, pushes0, rd0, done0;
        cur.lat  = 3;
        cur.res  = 32'd0;
        cur.stat = 32'd0;
        cur.ptr  = 10'd0;
        bus.out_full = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // Single EVP
        s0 = start_cycles.size(); pc0 = push_cycles.size(); dc0 = done_cycles.size();
        pp0 = pop_cycles.size(); k0 = clr_cnt;
        add_cfg(20, 32'd17, 32'd0, 10'd4);
        expq.push_back(32'd17); expq.push_back(32'd0);
        ififo.push_back(32'h3400_0002);
        wait_pushes(pc0 + 2, 100);
        tick(); tick();
        check_eq("t1_starts", 32'(start_cycles.size() - s0), 32'd1);
        check_eq("t1_clear_cycles", 32'(clr_cnt - k0), 32'd1);
        check_eq("t1_A_x", start_ax[s0], {13'd0, 3'd2, 16'd2});
        check_eq("t1_pop_to_start", 32'(start_cycles[s0] - pop_cycles[pp0]), 32'd4);
        check_eq("t1_done_to_push", 32'(push_cycles[pc0] - done_cycles[dc0]), 32'd1);
        check_eq("t1_push_gap", 32'(push_cycles[pc0 + 1] - push_cycles[pc0]), 32'd1);
        check_eq("t1_rd_addr", 32'(bus.rd_addr_data), 32'd4);
        check_eq("t1_idle", 32'(bus.busy), 32'd0);

        // Back-to-back EVPs, pointer wrap, done on WAIT entry
        s0 = start_cycles.size(); pc0 = push_cycles.size(); dc0 = done_cycles.size();
        pp0 = pop_cycles.size();
        add_cfg(4, 32'd5, 32'd0, 10'd1023);
        add_cfg(1, 32'd6, 32'd1, 10'd3);
        expq.push_back(32'd5); expq.push_back(32'd0);
        expq.push_back(32'd6); expq.push_back(32'd1);
        ififo.push_back(32'h3E00_00FF);
        ififo.push_back(32'h3000_8000);
        wait_pushes(pc0 + 4, 150);
        tick(); tick();
        check_eq("t2_ptr_first", start_ptr[s0], 32'd4);
        check_eq("t2_ptr_second", start_ptr[s0 + 1], 32'd1023);
        check_eq("t2_A_x_first", start_ax[s0], {13'd0, 3'd7, 16'h00FF});
        check_eq("t2_A_x_second", start_ax[s0 + 1], {13'd0, 3'd0, 16'h8000});
        check_eq("t2_next_pop", 32'(pop_cycles[pp0 + 1] - done_cycles[dc0]), 32'd3);
        check_eq("t2_wait_entry_done", 32'(done_cycles[dc0 + 1] - start_cycles[s0 + 1]), 32'd1);
        check_eq("t2_rd_addr_wrap", 32'(bus.rd_addr_data), 32'd3);

        // Illegal opcode
        s0 = start_cycles.size(); pc0 = push_cycles.size(); pp0 = pop_cycles.size();
        k0 = clr_cnt;
        expq.push_back(32'd0); expq.push_back(32'd3);
        ififo.push_back(32'h5000_0000);
        wait_pushes(pc0 + 2, 40);
        tick(); tick();
        check_eq("t3_no_start", 32'(start_cycles.size() - s0), 32'd0);
        check_eq("t3_no_clear", 32'(clr_cnt - k0), 32'd0);
        check_eq("t3_push_res_cycle", 32'(push_cycles[pc0] - pop_cycles[pp0]), 32'd3);
        check_eq("t3_push_stat_cycle", 32'(push_cycles[pc0 + 1] - pop_cycles[pp0]), 32'd4);
        check_eq("t3_rd_addr", 32'(bus.rd_addr_data), 32'd3);

        // Backpressure on both words
        pc0 = push_cycles.size(); dc0 = done_cycles.size();
        add_cfg(5, 32'd21, 32'd2, 10'd9);
        expq.push_back(32'd21); expq.push_back(32'd2);
        bus.out_full = 1'b1;
        ififo.push_back(32'h3600_0010);
        wait_done(dc0 + 1, 40);
        repeat (5) tick();
        check_eq("t4_held_while_full", 32'(push_cnt - pc0), 32'd0);
        bus.out_full = 1'b0;
        wait_pushes(pc0 + 1, 20);
        bus.out_full = 1'b1;
        tick(); tick();
        check_eq("t4_stat_held", 32'(push_cnt - pc0), 32'd1);
        bus.out_full = 1'b0;
        wait_pushes(pc0 + 2, 20);
        repeat (5) tick();
        check_eq("t4_push_count", 32'(push_cnt - pc0), 32'd2);
        check_eq("t4_rd_addr", 32'(bus.rd_addr_data), 32'd9);

        // Reset during WAIT, then a clean instruction from pointer 0
        s0 = start_cycles.size(); pushes0 = push_cnt;
        add_cfg(30, 32'hDEAD_0000, 32'd0, 10'd77);
        ififo.push_back(32'h33AB_1234);
        wait_starts(s0 + 1, 30);
        check_eq("t5_A_x", start_ax[s0], {13'd0, 3'd1, 16'h1234});
        repeat (5) tick();
        done0 = done_cycles.size();
        rst = 1'b1;
        tick();
        check_reset("t5_reset");
        rst = 1'b0;
        repeat (40) tick();
        check_eq("t5_no_push", 32'(push_cnt - pushes0), 32'd0);
        check_eq("t5_eval_abandoned", 32'(done_cycles.size() - done0), 32'd0);
        s0 = start_cycles.size(); pc0 = push_cycles.size();
        add_cfg(3, 32'd9, 32'd0, 10'd7);
        expq.push_back(32'd9); expq.push_back(32'd0);
        ififo.push_back(32'h3400_0002);
        wait_pushes(pc0 + 2, 40);
        tick(); tick();
        check_eq("t5_ptr_from_zero", start_ptr[s0], 32'd0);
        check_eq("t5_rd_addr", 32'(bus.rd_addr_data), 32'd7);

        // Empty FIFO with a spurious done in IDLE
        rd0 = pop_cycles.size(); pushes0 = push_cnt;
        spur_req = 1'b1;
        tick();
        spur_req = 1'b0;
        repeat (10) tick();
        check_eq("t6_no_pop", 32'(pop_cycles.size() - rd0), 32'd0);
        check_eq("t6_no_push", 32'(push_cnt - pushes0), 32'd0);
        check_eq("t6_idle", 32'(bus.busy), 32'd0);
        check_eq("t6_rd_addr", 32'(bus.rd_addr_data), 32'd7);

        check_eq("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
